// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one producer input (d/s/valid_in/ready_in)
// and two consumer outputs, plus per-output push counters. The DUT uses the slave modport.
interface demux_stream_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] d;
  logic             s;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] y0;
  logic             valid0;
  logic             ready0;
  logic [WIDTH-1:0] y1;
  logic             valid1;
  logic             ready1;
  logic [15:0]      count0;
  logic [15:0]      count1;

  // The master side drives the producer signals and the two consumer readies.
  modport master (
    output d, s, valid_in, ready0, ready1,
    input  ready_in, y0, valid0, y1, valid1, count0, count1
  );

  modport slave (
    input  d, s, valid_in, ready0, ready1,
    output ready_in, y0, valid0, y1, valid1, count0, count1
  );
endinterface

// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer with a small FIFO per output.
// Define DEMUX_STREAM_STATS_EN to build the saturating per-output push counters.
module demux_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  demux_stream_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]       dest;
  logic [1:0]       rdy;
  logic [1:0]       vld;
  logic [AW:0]      occ  [2];
  logic [WIDTH-1:0] head [2];
  logic [15:0]      cnt  [2];

  assign dest = {bus.s, ~bus.s};
  assign rdy  = {bus.ready1, bus.ready0};

  // Only the selected FIFO gates acceptance; a full FIFO never takes a word even while popped.
  assign bus.ready_in = (bus.s ? occ[1] : occ[0]) < FULL;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic             push;
    logic             pop;

    assign push = bus.valid_in && bus.ready_in && dest[ch];
    assign pop  = vld[ch] && rdy[ch];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fill <= fill + (AW+1)'(1);
          2'b01:   fill <= fill - (AW+1)'(1);
          default: fill <= fill;
        endcase
      end
    end

    // Storage is never reset, so the head is masked whenever the FIFO is empty.
    assign occ[ch]  = fill;
    assign vld[ch]  = (fill != '0);
    assign head[ch] = vld[ch] ? mem[rd_ptr] : '0;

`ifdef DEMUX_STREAM_STATS_EN
    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= '0;
      end else if (push && (count != 16'hFFFF)) begin
        count <= count + 16'd1;
      end
    end

    assign cnt[ch] = count;
`else
    assign cnt[ch] = 16'h0000;
`endif
  end

  assign bus.y0     = head[0];
  assign bus.valid0 = vld[0];
  assign bus.y1     = head[1];
  assign bus.valid1 = vld[1];
  assign bus.count0 = cnt[0];
  assign bus.count1 = cnt[1];
endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus random traffic
// checked against a queue-based reference model of the two output FIFOs.
module tb_demux_stream;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
`ifdef DEMUX_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  demux_stream_if #(.WIDTH(WIDTH)) bus ();

  demux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each output is a bounded queue; counters saturate at 16 bits.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int unsigned mcnt0 = 0;
  int unsigned mcnt1 = 0;

  function automatic int msize(input logic ch);
    return ch ? q1.size() : q0.size();
  endfunction

  function automatic logic [31:0] mhead(input logic ch);
    if (ch) return (q1.size() != 0) ? q1[0] : 32'h0;
    return (q0.size() != 0) ? q0[0] : 32'h0;
  endfunction

  function automatic int unsigned bump(input int unsigned c);
    if (STATS) return (c < 65535) ? c + 1 : c;
    return 0;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mcnt0 = 0;
    mcnt1 = 0;
  endtask

  // One clock edge: decide pops/push from pre-edge state, then update the model.
  task automatic tick();
    logic p0, p1, push, sel;
    logic [31:0] data;
    p0   = bus.ready0 && (q0.size() != 0);
    p1   = bus.ready1 && (q1.size() != 0);
    sel  = bus.s;
    data = bus.d;
    push = bus.valid_in && (msize(sel) < DEPTH);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (push) begin
      if (sel) begin
        q1.push_back(data);
        mcnt1 = bump(mcnt1);
      end else begin
        q0.push_back(data);
        mcnt0 = bump(mcnt0);
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.s = 1'b0;
    bus.d = '0;
    bus.ready0 = 1'b0;
    bus.ready1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++; if (bus.valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid0: got %b expected 0", bus.valid0); end
    vectors++; if (bus.valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid1: got %b expected 0", bus.valid1); end
    vectors++; if (bus.y0 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_y0: got %h expected 0", bus.y0); end
    vectors++; if (bus.y1 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_y1: got %h expected 0", bus.y1); end
    vectors++; if (bus.count0 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_count0: got %h expected 0", bus.count0); end
    vectors++; if (bus.count1 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_count1: got %h expected 0", bus.count1); end
    vectors++; if (bus.ready_in !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready_s0: got %b expected 1", bus.ready_in); end
    bus.s = 1'b1;
    #1;
    vectors++; if (bus.ready_in !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready_s1: got %b expected 1", bus.ready_in); end
    bus.s = 1'b0;
  endtask

  task automatic test_steering();
    logic [15:0] one;
    one = STATS ? 16'd1 : 16'd0;
    apply_reset();
    bus.valid_in = 1'b1;
    bus.s = 1'b0;
    bus.d = 32'hDEAD0001;
    tick();
    vectors++; if (bus.valid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL steer_valid0: got %b expected 1", bus.valid0); end
    vectors++; if (bus.y0 !== 32'hDEAD0001) begin miscompares++; $display("[TB] FAIL steer_y0: got %h expected DEAD0001", bus.y0); end
    vectors++; if (bus.valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL steer_valid1_early: got %b expected 0", bus.valid1); end
    bus.s = 1'b1;
    bus.d = 32'hBEEF0002;
    tick();
    bus.valid_in = 1'b0;
    #1;
    vectors++; if (bus.valid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL steer_valid1: got %b expected 1", bus.valid1); end
    vectors++; if (bus.y1 !== 32'hBEEF0002) begin miscompares++; $display("[TB] FAIL steer_y1: got %h expected BEEF0002", bus.y1); end
    vectors++; if (bus.y0 !== 32'hDEAD0001) begin miscompares++; $display("[TB] FAIL steer_y0_hold: got %h expected DEAD0001", bus.y0); end
    vectors++; if (bus.count0 !== one) begin miscompares++; $display("[TB] FAIL steer_count0: got %h expected %h", bus.count0, one); end
    vectors++; if (bus.count1 !== one) begin miscompares++; $display("[TB] FAIL steer_count1: got %h expected %h", bus.count1, one); end
  endtask

  task automatic test_full();
    logic [31:0] seen[$];
    apply_reset();
    bus.valid_in = 1'b1;
    bus.s = 1'b0;
    bus.d = 32'd1;
    tick();
    bus.d = 32'd2;
    tick();
    bus.d = 32'd3;
    #1;
    vectors++; if (bus.ready_in !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready_s0: got %b expected 0", bus.ready_in); end
    bus.s = 1'b1;
    #1;
    vectors++; if (bus.ready_in !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ready_s1: got %b expected 1", bus.ready_in); end
    bus.s = 1'b0;
    bus.ready0 = 1'b1;
    #1;
    vectors++; if (bus.ready_in !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready_while_pop: got %b expected 0", bus.ready_in); end
    if (bus.valid0) seen.push_back(bus.y0);
    tick();
    bus.ready0 = 1'b0;
    #1;
    vectors++; if (bus.y0 !== 32'd2) begin miscompares++; $display("[TB] FAIL full_y0_advance: got %h expected 2", bus.y0); end
    vectors++; if (bus.ready_in !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ready_after_pop: got %b expected 1", bus.ready_in); end
    tick();
    bus.valid_in = 1'b0;
    bus.ready0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.valid0) seen.push_back(bus.y0);
      tick();
    end
    bus.ready0 = 1'b0;
    vectors++; if (seen.size() !== 3) begin miscompares++; $display("[TB] FAIL full_order_len: got %0d expected 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      vectors++;
      if (seen[i] !== 32'(i + 1)) begin miscompares++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", i, seen[i], i + 1); end
    end
  endtask

  task automatic test_stream();
    apply_reset();
    bus.valid_in = 1'b1;
    bus.s = 1'b0;
    bus.d = 32'd9;
    tick();
    bus.ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.d = 32'(10 + i);
      #1;
      vectors++; if (bus.ready_in !== 1'b1 || bus.valid0 !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_occ1[%0d]: got ready_in=%b valid0=%b expected 1/1", i, bus.ready_in, bus.valid0); end
      tick();
      vectors++; if (bus.y0 !== 32'(10 + i)) begin miscompares++; $display("[TB] FAIL stream_y0[%0d]: got %h expected %h", i, bus.y0, 10 + i); end
    end
    bus.valid_in = 1'b0;
    bus.ready0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.valid_in = 1'b1;
    bus.s = 1'b0; bus.d = 32'hA1; tick();
    bus.d = 32'hA2; tick();
    bus.s = 1'b1; bus.d = 32'hB1; tick();
    bus.d = 32'hB2; tick();
    bus.valid_in = 1'b0;
    #1;
    vectors++; if (bus.valid0 !== 1'b1 || bus.valid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_prefill: got %b%b expected 11", bus.valid0, bus.valid1); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid0: got %b expected 0", bus.valid0); end
    vectors++; if (bus.valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid1: got %b expected 0", bus.valid1); end
    vectors++; if (bus.y0 !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_y0: got %h expected 0", bus.y0); end
    vectors++; if (bus.y1 !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_y1: got %h expected 0", bus.y1); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.valid_in = 1'b1;
    bus.s = 1'b1;
    bus.d = 32'hC0FFEE;
    tick();
    bus.valid_in = 1'b0;
    #1;
    vectors++; if (bus.valid1 !== 1'b1 || bus.y1 !== 32'hC0FFEE) begin miscompares++; $display("[TB] FAIL mid_new_word: got %b/%h expected 1/00C0FFEE", bus.valid1, bus.y1); end
    vectors++; if (bus.valid0 !== 1'b0 || bus.y0 !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_other_empty: got %b/%h expected 0/0", bus.valid0, bus.y0); end
    bus.ready1 = 1'b1;
    tick();
    bus.ready1 = 1'b0;
    vectors++; if (bus.valid1 !== 1'b0 || bus.y1 !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_no_stale: got %b/%h expected 0/0", bus.valid1, bus.y1); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.s = 1'($urandom_range(0, 1));
      bus.d = $urandom;
      bus.ready0 = ($urandom_range(0, 2) != 0);
      bus.ready1 = ($urandom_range(0, 2) == 0);
      #1;
      vectors++; if (bus.ready_in !== (msize(bus.s) < DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_ready_in[%0d]: got %b expected %b", n, bus.ready_in, msize(bus.s) < DEPTH); end
      vectors++; if (bus.valid0 !== (q0.size() != 0)) begin miscompares++; $display("[TB] FAIL rnd_valid0[%0d]: got %b expected %b", n, bus.valid0, q0.size() != 0); end
      vectors++; if (bus.valid1 !== (q1.size() != 0)) begin miscompares++; $display("[TB] FAIL rnd_valid1[%0d]: got %b expected %b", n, bus.valid1, q1.size() != 0); end
      vectors++; if (bus.y0 !== mhead(1'b0)) begin miscompares++; $display("[TB] FAIL rnd_y0[%0d]: got %h expected %h", n, bus.y0, mhead(1'b0)); end
      vectors++; if (bus.y1 !== mhead(1'b1)) begin miscompares++; $display("[TB] FAIL rnd_y1[%0d]: got %h expected %h", n, bus.y1, mhead(1'b1)); end
      vectors++; if (bus.count0 !== 16'(mcnt0)) begin miscompares++; $display("[TB] FAIL rnd_count0[%0d]: got %h expected %h", n, bus.count0, 16'(mcnt0)); end
      vectors++; if (bus.count1 !== 16'(mcnt1)) begin miscompares++; $display("[TB] FAIL rnd_count1[%0d]: got %h expected %h", n, bus.count1, 16'(mcnt1)); end
      tick();
    end
    bus.valid_in = 1'b0;
    bus.ready0 = 1'b0;
    bus.ready1 = 1'b0;
  endtask

  task automatic test_stats_sat();
    logic [15:0] top;
    top = STATS ? 16'hFFFF : 16'h0000;
    apply_reset();
    bus.ready1 = 1'b1;
    bus.valid_in = 1'b1;
    bus.s = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.d = 32'(i);
      tick();
      if (i == 1000) begin
        vectors++; if (bus.count1 !== 16'(mcnt1)) begin miscompares++; $display("[TB] FAIL sat_count1_mid: got %h expected %h", bus.count1, 16'(mcnt1)); end
      end
    end
    vectors++; if (bus.count1 !== top) begin miscompares++; $display("[TB] FAIL sat_count1: got %h expected %h", bus.count1, top); end
    vectors++; if (bus.count0 !== 16'h0) begin miscompares++; $display("[TB] FAIL sat_count0: got %h expected 0", bus.count0); end
    tick();
    tick();
    bus.valid_in = 1'b0;
    #1;
    vectors++; if (bus.count1 !== top) begin miscompares++; $display("[TB] FAIL sat_count1_hold: got %h expected %h", bus.count1, top); end
    vectors++; if (bus.y1 !== mhead(1'b1)) begin miscompares++; $display("[TB] FAIL sat_y1: got %h expected %h", bus.y1, mhead(1'b1)); end
    bus.ready1 = 1'b0;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.s = 1'b0;
    bus.d = '0;
    bus.ready0 = 1'b0;
    bus.ready1 = 1'b0;
    $display("[TB] demux_stream bench start (stats build = %0d)", STATS);
    test_reset();
    test_steering();
    test_full();
    test_stream();
    test_reset_mid();
    test_random();
    test_stats_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- 1-to-2 stream demultiplexer with per-output buffering. It is the distributing counterpart of the datapath 2:1 selectors.
- Each incoming word is steered by select S to output 0 or output 1. Each output has its own small FIFO and a valid/ready handshake.
- Sits between a single result producer (ALU/memory return path) and two independent consumers. Either consumer may stall without losing data.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per output FIFO; power of two, >= 2.

Ports:
- CLK  input  1  clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- D  input  WIDTH  input data word.
- S  input  1  destination select: 0 -> output 0, 1 -> output 1.
- VALID_IN  input  1  D/S valid.
- READY_IN  output  1  block can accept D this cycle.
- Y0  output  WIDTH  output 0 head word.
- VALID0  output  1  Y0 valid.
- READY0  input  1  consumer 0 accepts Y0.
- Y1  output  WIDTH  output 1 head word.
- VALID1  output  1  Y1 valid.
- READY1  input  1  consumer 1 accepts Y1.
- COUNT0  output  16  words accepted into output 0 (stats).
- COUNT1  output  16  words accepted into output 1 (stats).

Behaviour:
- Interface clocking and reset: one clock, CLK. RST_N is asynchronous, active-low.
- Reset (RST_N low, any time, including mid-transfer): all FIFO pointers and occupancies are cleared. VALID0 = VALID1 = 0, Y0 = Y1 = 0, COUNT0 = COUNT1 = 0. Buffered data is discarded.
- Occupancy: OCC0 and OCC1, each of width clog2(DEPTH)+1, range 0..DEPTH.
- READY_IN is combinational: READY_IN = (S ? OCC1 : OCC0) < DEPTH.
  - Depends only on S and the selected FIFO. The other FIFO's state has no effect.
  - A full FIFO does not accept on a cycle it is popped; there is no pass-through when full.
- Push: VALID_IN && READY_IN at a rising CLK edge writes D into FIFO[S] and increments its write pointer.
- Pop: VALIDn && READYn at a rising CLK edge removes the FIFOn head.
- Simultaneous push and pop on the same FIFO: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a word pushed at edge k has VALIDn = 1 and appears on Yn after edge k (one cycle).
- Empty FIFO: no bypass from D to Yn.
- VALIDn = (OCCn != 0), registered-derived with no combinational path from VALID_IN, D or READYn.
- Yn = FIFO head word when VALIDn = 1, else 0.
- READYn while VALIDn = 0 has no effect.
- Ordering: per-output FIFO order is preserved. No ordering is implied between the two outputs.
- VALID_IN low: D and S are ignored; no state change except pops.

Optional Feature:
- Macro: DEMUX_STREAM_STATS_EN.
- Defined:
  - COUNTn increments by 1 on every push into FIFOn.
  - COUNTn saturates at 16'hFFFF and never wraps.
  - COUNTn resets to 0 with RST_N.
- Not defined:
  - Counter registers are not built.
  - COUNT0 and COUNT1 are tied to 16'h0000.
  - Ports remain present so instantiations are identical in both builds.

Test Plan:
- Reset/idle: RST_N low for 2 cycles, then high with VALID_IN = 0 -> VALID0 = VALID1 = 0, Y0 = Y1 = 0, READY_IN = 1 for S = 0 and S = 1, COUNT0 = COUNT1 = 0.
- Steering and latency: push D = 32'hDEAD0001 with S = 0 and D = 32'hBEEF0002 with S = 1 on consecutive cycles, READY0 = READY1 = 0.
  - Cycle after the first push: VALID0 = 1, Y0 = DEAD0001.
  - Cycle after the second push: VALID1 = 1, Y1 = BEEF0002.
  - Stats build: COUNT0 = COUNT1 = 1.
- Full/back-pressure: READY0 = 0, push 1, 2, 3 with S = 0.
  - READY_IN drops after 2 accepts, with 3 held.
  - With S = 1, READY_IN = 1 while FIFO0 is full.
  - Pulse READY0 for one cycle: Y0 advances 1 -> 2 and 3 is accepted the following cycle.
  - Final output order on Y0: 1, 2, 3.
- Simultaneous push/pop and wrap: OCC0 = 1, READY0 = 1, VALID_IN = 1, S = 0 streaming 10..17 for 8 cycles.
  - OCC0 stays 1.
  - Y0 sequence is 10..17 with no gaps or duplicates.
  - Write and read pointers wrap 4 times.
- Reset mid-operation: with both FIFOs holding 2 words, assert RST_N low asynchronously between edges.
  - VALID0, VALID1, Y0, Y1 go to 0 immediately, before the next edge.
  - After release, a new push appears alone on its output with no stale words.
- Stats saturation (DEMUX_STREAM_STATS_EN defined): force 65537 pushes to output 1 with READY1 = 1 -> COUNT1 = 16'hFFFF and holds; COUNT0 = 0. Without the macro, COUNT1 = 0 throughout.
